rom_load_sequencer: RTL and testbench
=====================================

Name: rom_load_sequencer

Overview:
- Sequences the HPS ROM download into the arcade core's ROM and PROM regions.
- Decodes the ioctl byte stream into per-region write strobes with local addresses, and counts the bytes received.
- Holds the core in reset from the start of the download until a settle period has elapsed after it ends.
- Flags short, overlong or corrupt downloads; sits between hps_io and the core's dn_* interface.

Parameters:
- SETTLE_CYCLES, 1024: clk_sys cycles the core stays in reset after ioctl_download falls; minimum 1.
- TOTAL_BYTES, 43136 (0xA880): expected download length in bytes.
- EXPECTED_SUM, 16'h0000: reference checksum; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  a download is in progress.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- rgn_we  out  4  one-hot write strobe per region.
- rgn_addr  out  16  address local to the selected region.
- rgn_data  out  8  registered byte.
- core_reset  out  1  active-high reset to the core.
- load_done  out  1  high in RUN after a good load.
- load_error  out  1  sticky error flag; cleared at the next download start.
- byte_count  out  17  bytes accepted in the current or last download.

Behaviour:
- Reset values: rgn_we=0, rgn_addr=0, rgn_data=0, core_reset=1, load_done=0, load_error=0, byte_count=0, state=IDLE.
- Region map (byte addresses, local address = ioctl_addr minus region base):
  - R0 CPU: 0x0000-0x5FFF
  - R1 tiles: 0x6000-0x8FFF
  - R2 sprites: 0x9000-0xA7FF
  - R3 PROM: 0xA800-0xA87F
- Write path, valid only when ioctl_download=1:
  - An ioctl_wr with an address inside the map gives exactly one rgn_we pulse one cycle later.
  - rgn_addr and rgn_data are valid in the same cycle as that pulse; latency is 1.
  - byte_count increments per accepted byte and saturates at 0x1FFFF.
- Out-of-map writes (addr at or above 0xA880, or bits 24:16 nonzero):
  - No strobe is issued.
  - load_error is set.
  - byte_count does not increment.
- ioctl_wr while ioctl_download=0 is ignored entirely.
- State machine:
  - IDLE: core_reset=1. ioctl_download rising goes to LOAD; otherwise stays in IDLE.
  - LOAD: core_reset=1. On the first LOAD cycle, byte_count, load_error and load_done clear. Writes are accepted. ioctl_download falling goes to SETTLE.
  - SETTLE: core_reset=1. The counter counts down from SETTLE_CYCLES-1. On exit, if byte_count != TOTAL_BYTES, load_error is set. Counter reaching 0 goes to RUN.
  - RUN: core_reset=0. load_done = ~load_error.
- A failed load still enters RUN. load_error is visible to the OSD or LED logic and does not block the core.
- ioctl_download rising in SETTLE or RUN:
  - Go to LOAD immediately.
  - core_reset=1 in the same cycle, combinational from state-next.
- ioctl_wr coincident with the falling edge of ioctl_download: the byte is still accepted and strobed.
- reset_n low at any point: all state returns to reset values asynchronously. Any strobe in flight is dropped. A download still active when reset_n rises is re-entered as LOAD, because IDLE checks the level of ioctl_download on the first cycle, not only the edge.

Optional Feature:
- Macro: ROM_LOAD_CHECKSUM_EN.
- When defined:
  - A 16-bit wrapping sum of all accepted bytes is kept (zero-extended adds).
  - The sum clears at LOAD entry.
  - On SETTLE exit, if sum != EXPECTED_SUM, load_error is set.
  - Extra output port `sum_out` (16 bits) carries the sum.
- When undefined: no adder, no `sum_out` port, and EXPECTED_SUM is unused.

Decomposition:
- Package rom_load_pkg holds:
  - the region base and limit localparams;
  - the NUM_RGN=4 constant;
  - the state enum typedef {IDLE, LOAD, SETTLE, RUN};
  - the function rgn_decode(addr) returning a one-hot region plus a valid bit.
- One sub-module: rom_load_settle_timer. It is a loadable down-counter with start and expired signals, width $clog2(SETTLE_CYCLES).

Test Plan:
- Reset and idle: hold reset_n=0 for 5 cycles, then release with no download -> core_reset=1, rgn_we=0, load_done=0 indefinitely.
- Full load: stream 0xA880 bytes, data = addr[7:0]:
  - each byte gives one rgn_we pulse one cycle later;
  - addr 0x6000 -> rgn_we=4'b0010, rgn_addr=0;
  - addr 0xA87F -> rgn_we=4'b1000, rgn_addr=0x7F;
  - after SETTLE_CYCLES, core_reset=0, load_done=1, byte_count=0xA880.
- Short load: stop after 0x6000 bytes -> load_error=1 in RUN, load_done=0, core_reset releases.
- Out-of-map write: one write at 0xB000 within a full load -> no strobe, byte_count=0xA880, load_error=1.
- Re-download during RUN: assert ioctl_download -> core_reset=1 in the same cycle, load_error and byte_count cleared the next cycle; a clean reload ends with load_done=1.
- Async reset mid-LOAD at byte 0x100 (checksum build also stream an incorrect sum) -> outputs return to reset values immediately; after release with download still high, state is LOAD; with ROM_LOAD_CHECKSUM_EN defined and a wrong EXPECTED_SUM, load_error=1.

Source files
------------

// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - region map, state encoding and address decode for the ROM load sequencer
package rom_load_pkg;

    localparam int NUM_RGN = 4;

    localparam logic [24:0] R0_BASE  = 25'h000_0000;
    localparam logic [24:0] R0_LIMIT = 25'h000_5FFF;
    localparam logic [24:0] R1_BASE  = 25'h000_6000;
    localparam logic [24:0] R1_LIMIT = 25'h000_8FFF;
    localparam logic [24:0] R2_BASE  = 25'h000_9000;
    localparam logic [24:0] R2_LIMIT = 25'h000_A7FF;
    localparam logic [24:0] R3_BASE  = 25'h000_A800;
    localparam logic [24:0] R3_LIMIT = 25'h000_A87F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [NUM_RGN-1:0] onehot;
        logic [15:0]        local_addr;
    } rgn_dec_t;

    // Any address above R3_LIMIT, including nonzero bits 24:16, decodes as invalid.
    function automatic rgn_dec_t rgn_decode(input logic [24:0] addr);
        rgn_dec_t r;
        r = '0;
        if (addr <= R0_LIMIT) begin
            r.valid      = 1'b1;
            r.onehot     = 4'b0001;
            r.local_addr = 16'(addr - R0_BASE);
        end else if (addr <= R1_LIMIT) begin
            r.valid      = 1'b1;
            r.onehot     = 4'b0010;
            r.local_addr = 16'(addr - R1_BASE);
        end else if (addr <= R2_LIMIT) begin
            r.valid      = 1'b1;
            r.onehot     = 4'b0100;
            r.local_addr = 16'(addr - R2_BASE);
        end else if (addr <= R3_LIMIT) begin
            r.valid      = 1'b1;
            r.onehot     = 4'b1000;
            r.local_addr = 16'(addr - R3_BASE);
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_load_settle_timer.sv
// rtl/rom_load_settle_timer.sv - loadable down-counter timing the post-download reset hold
module rom_load_settle_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - turns the ioctl download into region strobes and holds the core in reset
// Define ROM_LOAD_CHECKSUM_EN to add a running byte sum checked against EXPECTED_SUM (sum_out port).
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned TOTAL_BYTES   = 43136
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECTED_SUM  = 16'h0000
`endif
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic [NUM_RGN-1:0] rgn_we,
    output logic [15:0]        rgn_addr,
    output logic [7:0]         rgn_data,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [16:0]        byte_count
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    output logic [15:0]        sum_out
`endif
);

    localparam logic [16:0] BYTE_MAX = 17'h1FFFF;
    localparam logic [16:0] TOTAL    = 17'(TOTAL_BYTES);

    state_t             state_q, state_d;
    logic [NUM_RGN-1:0] we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [16:0]        count_q, count_d;
    logic               err_q, err_d;
    logic               tmr_start, tmr_expired;
    logic               load_entry, settle_exit, wr_take, sum_bad;
    rgn_dec_t           dec;

    assign dec = rgn_decode(ioctl_addr);

    // A write coinciding with the fall of ioctl_download still belongs to this load.
    assign wr_take = ioctl_wr && (ioctl_download || (state_q == LOAD));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (ioctl_download) state_d = LOAD;
            LOAD:   if (!ioctl_download) state_d = SETTLE;
            SETTLE: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                end else if (tmr_expired) begin
                    state_d = RUN;
                end
            end
            RUN:    if (ioctl_download) state_d = LOAD;
        endcase
    end

    assign load_entry  = (state_d == LOAD) && (state_q != LOAD);
    assign settle_exit = (state_q == SETTLE) && (state_d == RUN);
    assign tmr_start   = (state_q == LOAD) && (state_d == SETTLE);

    rom_load_settle_timer #(
        .CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk_i    (clk_sys),
        .rst_n_i  (reset_n),
        .start_i  (tmr_start),
        .en_i     (state_q == SETTLE),
        .expired_o(tmr_expired)
    );

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = load_entry ? 16'h0000 : sum_q;
        if (wr_take && dec.valid) begin
            sum_d = sum_d + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_bad = (sum_q != EXPECTED_SUM);
    assign sum_out = sum_q;
`else
    assign sum_bad = 1'b0;
`endif

    always_comb begin
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = load_entry ? 17'h0 : count_q;
        err_d   = load_entry ? 1'b0 : err_q;
        if (wr_take) begin
            if (dec.valid) begin
                we_d   = dec.onehot;
                addr_d = dec.local_addr;
                data_d = ioctl_dout;
                if (count_d != BYTE_MAX) begin
                    count_d = count_d + 17'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (settle_exit && ((count_q != TOTAL) || sum_bad)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= '0;
            addr_q  <= 16'h0;
            data_q  <= 8'h0;
            count_q <= 17'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Looking at state_d lets a re-download re-assert reset in the cycle it is seen.
    assign core_reset = (state_q != RUN) || (state_d != RUN);
    assign load_done  = (state_q == RUN) && !err_q;
    assign load_error = err_q;
    assign byte_count = count_q;
    assign rgn_we     = we_q;
    assign rgn_addr   = addr_q;
    assign rgn_data   = data_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - scoreboard bench for rom_load_sequencer
module tb_rom_load_sequencer;

    localparam int          SETTLE  = 16;
    localparam int          TOTAL   = 32'hA880;
    localparam logic [15:0] EXP_SUM = 16'hCBC0;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [3:0]  rgn_we;
    logic [15:0] rgn_addr;
    logic [7:0]  rgn_data;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [16:0] byte_count;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] sum_out;
`endif

    typedef struct {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_count;
    logic        m_err;
    logic [15:0] m_sum;

    rom_load_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .TOTAL_BYTES  (TOTAL)
`ifdef ROM_LOAD_CHECKSUM_EN
        ,
        .EXPECTED_SUM (EXP_SUM)
`endif
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .rgn_we        (rgn_we),
        .rgn_addr      (rgn_addr),
        .rgn_data      (rgn_data),
        .core_reset    (core_reset),
        .load_done     (load_done),
        .load_error    (load_error),
        .byte_count    (byte_count)
`ifdef ROM_LOAD_CHECKSUM_EN
        ,
        .sum_out       (sum_out)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        if (rgn_we != 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("spurious_we", {28'h0, rgn_we}, 32'h0);
            end else begin
                e = sb.pop_front();
                check_eq("strobe_we", {28'h0, rgn_we}, {28'h0, e.we});
                check_eq("strobe_addr", {16'h0, rgn_addr}, {16'h0, e.addr});
                check_eq("strobe_data", {24'h0, rgn_data}, {24'h0, e.data});
                check_eq("strobe_latency", cyc - e.stamp, 1);
            end
        end else if (sb.size() != 0 && sb[0].stamp == cyc - 1) begin
            e = sb.pop_front();
            check_eq("missed_we", {28'h0, rgn_we}, {28'h0, e.we});
        end
    end

    task automatic start_model();
        m_count = 0;
        m_err   = 1'b0;
        m_sum   = 16'h0;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
        exp_t e;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (last) ioctl_download = 1'b0;
        e.stamp = cyc;
        e.data  = d;
        e.addr  = 16'h0;
        if (a < 25'h6000) begin
            e.we = 4'b0001; e.addr = 16'(a);
        end else if (a < 25'h9000) begin
            e.we = 4'b0010; e.addr = 16'(a - 25'h6000);
        end else if (a < 25'hA800) begin
            e.we = 4'b0100; e.addr = 16'(a - 25'h9000);
        end else if (a < 25'hA880) begin
            e.we = 4'b1000; e.addr = 16'(a - 25'hA800);
        end else begin
            e.we = 4'b0000;
        end
        if (e.we != 4'b0000) begin
            sb.push_back(e);
            m_count++;
            m_sum = m_sum + {8'h00, d};
        end else begin
            m_err = 1'b1;
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic stray_wr(input logic [24:0] a);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = 8'hC3;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 1;
        while (core_reset && n < SETTLE + 10) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq(tag, n, SETTLE + 1);
    endtask

    task automatic check_run();
        logic e;
        e = m_err || (m_count != TOTAL);
`ifdef ROM_LOAD_CHECKSUM_EN
        if (m_sum != EXP_SUM) e = 1'b1;
        check_eq("sum_out", {16'h0, sum_out}, {16'h0, m_sum});
`endif
        check_eq("run_core_reset", {31'h0, core_reset}, 32'h0);
        check_eq("run_byte_count", {15'h0, byte_count}, m_count);
        check_eq("run_load_error", {31'h0, load_error}, {31'h0, e});
        check_eq("run_load_done", {31'h0, load_done}, {31'h0, !e});
        check_eq("sb_drained", sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_we"}, {28'h0, rgn_we}, 32'h0);
        check_eq({tag, "_addr"}, {16'h0, rgn_addr}, 32'h0);
        check_eq({tag, "_data"}, {24'h0, rgn_data}, 32'h0);
        check_eq({tag, "_core_reset"}, {31'h0, core_reset}, 32'h1);
        check_eq({tag, "_done"}, {31'h0, load_done}, 32'h0);
        check_eq({tag, "_error"}, {31'h0, load_error}, 32'h0);
        check_eq({tag, "_count"}, {15'h0, byte_count}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'h0;
        ioctl_dout     = 8'h0;
        start_model();
        repeat (5) @(negedge clk_sys);
        check_reset_vals("rst");

        // idle: no download, stray write must be ignored
        reset_n = 1'b1;
        @(negedge clk_sys);
        stray_wr(25'h0);
        repeat (20) begin
            @(negedge clk_sys);
            check_eq("idle_core_reset", {31'h0, core_reset}, 32'h1);
        end
        check_eq("idle_done", {31'h0, load_done}, 32'h0);
        check_eq("idle_count", {15'h0, byte_count}, 32'h0);

        // short load from IDLE with out-of-map writes early on
        start_model();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 32'h6000; i++) begin
            wr_byte(25'(i), 8'(i), 1'b0);
            if (i == 16) begin
                wr_byte(25'hB000, 8'h55, 1'b0);
                check_eq("oom_error", {31'h0, load_error}, 32'h1);
                wr_byte(25'h100_0005, 8'h66, 1'b0);
                check_eq("oom_count", {15'h0, byte_count}, m_count);
            end
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        wait_run("settle_len_short");
        check_run();
        stray_wr(25'h10);
        check_eq("run_stray_count", {15'h0, byte_count}, 32'h6000);

        // re-download during RUN, clean full load ending on a coincident write
        ioctl_download = 1'b1;
        #1;
        check_eq("redl_core_reset", {31'h0, core_reset}, 32'h1);
        @(negedge clk_sys);
        check_eq("redl_count_clr", {15'h0, byte_count}, 32'h0);
        check_eq("redl_error_clr", {31'h0, load_error}, 32'h0);
        check_eq("redl_done_clr", {31'h0, load_done}, 32'h0);
        start_model();
        for (int i = 0; i < TOTAL; i++) begin
            wr_byte(25'(i), 8'(i), i == TOTAL - 1);
        end
        wait_run("settle_len_full");
        check_run();

        // async reset mid-load with a strobe in flight
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        start_model();
        for (int i = 0; i < 32'h100; i++) begin
            wr_byte(25'(i), 8'(i) ^ 8'h5A, 1'b0);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h100;
        ioctl_dout = 8'h77;
        @(posedge clk_sys);
        #1;
        check_eq("inflight_we", {28'h0, rgn_we}, 32'h1);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_reset_vals("async");
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        start_model();
        @(negedge clk_sys);
        check_eq("rel_core_reset", {31'h0, core_reset}, 32'h1);
        for (int i = 0; i < 32'h20; i++) begin
            wr_byte(25'h9000 + 25'(i), 8'(i) + 8'h11, i == 32'h1F);
        end
        wait_run("settle_len_rel");
        check_run();

        repeat (3) @(negedge clk_sys);
        check_eq("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
